// File: rtl/dmem_pkg.sv
// Shared encodings, FSM state type and default latencies for the latency-modelled data memory.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int DEF_DEPTH_WORDS = 1024;
    localparam int DEF_HIT_LAT     = 1;
    localparam int DEF_MISS_LAT    = 4;
    localparam int DEF_TAG_W       = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dmemState_e;

    // Sign- or zero-extend a right-aligned byte (lane[7:0]) or half (lane[15:0]).
    function automatic logic [31:0] extendLane(input logic [15:0] lane,
                                               input logic        isHalf,
                                               input logic        zeroExt);
        logic signBit;
        signBit = zeroExt ? 1'b0 : (isHalf ? lane[15] : lane[7]);
        if (isHalf) begin
            return {{16{signBit}}, lane};
        end
        return {{24{signBit}}, lane[7:0]};
    endfunction

endpackage

// File: rtl/dmem_align.sv
// Combinational lane logic: store byte enables and replication, load extraction and
// extension, plus misalignment / illegal-size detection.
module dmem_align
    import dmem_pkg::*;
(
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        zeroExt,
    input  logic [31:0] storeData,
    input  logic [31:0] readWord,
    output logic [3:0]  byteEn,
    output logic [31:0] storeWord,
    output logic [31:0] loadData,
    output logic        alignErr
);

    logic [31:0] shifted;
    logic [15:0] halfLane;

    always_comb begin
        byteEn    = 4'b0000;
        storeWord = 32'd0;
        loadData  = 32'd0;
        alignErr  = 1'b0;
        shifted   = readWord >> {offset, 3'b000};
        halfLane  = offset[1] ? readWord[31:16] : readWord[15:0];

        case (size)
            SZ_BYTE: begin
                byteEn    = 4'b0001 << offset;
                storeWord = {4{storeData[7:0]}};
                loadData  = extendLane({8'd0, shifted[7:0]}, 1'b0, zeroExt);
            end
            SZ_HALF: begin
                alignErr  = offset[0];
                byteEn    = offset[1] ? 4'b1100 : 4'b0011;
                storeWord = {2{storeData[15:0]}};
                loadData  = extendLane(halfLane, 1'b1, zeroExt);
            end
            SZ_WORD: begin
                alignErr  = (offset != 2'b00);
                byteEn    = 4'b1111;
                storeWord = storeData;
                loadData  = readWord;
            end
            default: begin
                // Size 11 is illegal: flagged as an error, no lanes enabled.
                alignErr  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_latency.sv
// Word-organised data memory that answers one request at a time after a fixed
// hit or miss latency; the access itself happens on the last WAIT cycle.
module data_mem_latency
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
    parameter int HIT_LAT     = DEF_HIT_LAT,
    parameter int MISS_LAT    = DEF_MISS_LAT,
    parameter int TAG_W       = DEF_TAG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [TAG_W-1:0] req_pc,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_wdata,
    input  logic             req_we,
    input  logic [1:0]       req_size,
    input  logic             req_unsigned,
    input  logic             req_miss,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [TAG_W-1:0] resp_pc,
    output logic [31:0]      resp_data,
    output logic             resp_err,
    output logic [1:0]       dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready; the
    // request side is ready only in IDLE, the response side holds resp_* until taken.

    localparam int AW    = $clog2(DEPTH_WORDS);
    localparam int CNT_W = $clog2(MISS_LAT + 1);
    localparam logic [CNT_W-1:0] HIT_CNT  = CNT_W'(HIT_LAT - 1);
    localparam logic [CNT_W-1:0] MISS_CNT = CNT_W'(MISS_LAT - 1);

    dmemState_e       state;
    dmemState_e       stateNext;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] countNext;
    logic             accept;
    logic             doAccess;

    logic [TAG_W-1:0] capPc;
    logic [31:0]      capAddr;
    logic [31:0]      capWdata;
    logic             capWe;
    logic [1:0]       capSize;
    logic             capUnsigned;

    logic [31:0]      mem [DEPTH_WORDS];
    logic [AW-1:0]    capIdx;
    logic [31:0]      readWord;
    logic             outOfRange;
    logic             alignErr;
    logic             accErr;
    logic [3:0]       byteEn;
    logic [31:0]      storeWord;
    logic [31:0]      loadData;

    assign req_ready  = (state == ST_IDLE) && !rst;
    assign resp_valid = (state == ST_RESP);
    assign dbg_state  = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            count <= '0;
        end else begin
            state <= stateNext;
            count <= countNext;
        end
    end

    always_comb begin
        stateNext = state;
        countNext = count;
        accept    = 1'b0;
        doAccess  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    accept    = 1'b1;
                    stateNext = ST_WAIT;
                    countNext = req_miss ? MISS_CNT : HIT_CNT;
                end
            end
            ST_WAIT: begin
                if (count == '0) begin
                    doAccess  = 1'b1;
                    stateNext = ST_RESP;
                end else begin
                    countNext = count - 1'b1;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    stateNext = ST_IDLE;
                end
            end
            default: stateNext = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst && accept) begin
            capPc       <= req_pc;
            capAddr     <= req_addr;
            capWdata    <= req_wdata;
            capWe       <= req_we;
            capSize     <= req_size;
            capUnsigned <= req_unsigned;
        end
    end

    assign capIdx     = capAddr[AW+1:2];
    assign readWord   = mem[capIdx];
    assign outOfRange = (capAddr >> (AW + 2)) != 32'd0;
    assign accErr     = alignErr || outOfRange;

    dmem_align uAlign (
        .offset    (capAddr[1:0]),
        .size      (capSize),
        .zeroExt   (capUnsigned),
        .storeData (capWdata),
        .readWord  (readWord),
        .byteEn    (byteEn),
        .storeWord (storeWord),
        .loadData  (loadData),
        .alignErr  (alignErr)
    );

    // Gating on rst drops a store still waiting at a reset edge.
    always_ff @(posedge clk) begin
        if (!rst && doAccess && capWe && !accErr) begin
            for (int i = 0; i < 4; i++) begin
                if (byteEn[i]) begin
                    mem[capIdx][8*i +: 8] <= storeWord[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_pc   <= '0;
            resp_data <= 32'd0;
            resp_err  <= 1'b0;
        end else if (doAccess) begin
            resp_pc   <= capPc;
            resp_err  <= accErr;
            resp_data <= (accErr || capWe) ? 32'd0 : loadData;
        end
    end

endmodule

// File: tb/tb_data_mem_latency.sv
// Randomized and directed bench for data_mem_latency, checked every cycle against
// a byte-array style reference model.
module tb_data_mem_latency;

    localparam int DEPTH = 64;
    localparam int HIT   = 1;
    localparam int MISS  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_pc;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        req_miss;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_pc;
    logic [31:0] resp_data;
    logic        resp_err;
    logic [1:0]  dbg_state;

    data_mem_latency #(
        .DEPTH_WORDS (DEPTH),
        .HIT_LAT     (HIT),
        .MISS_LAT    (MISS),
        .TAG_W       (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_pc       (req_pc),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_miss     (req_miss),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_pc      (resp_pc),
        .resp_data    (resp_data),
        .resp_err     (resp_err),
        .dbg_state    (dbg_state)
    );

    // ---------------- clock / cycle count ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] exp_q[$];
    logic [31:0] pc_q[$];
    logic        err_q[$];

    logic [31:0] mmem [DEPTH];
    bit          pend_valid;
    int          pend_due;
    bit          pend_store;
    logic [31:0] pend_addr;
    logic [31:0] pend_wdata;
    logic [1:0]  pend_size;
    bit          post_reset;
    int          accept_count;
    int          last_accept_edge;
    int          last_hs_edge;
    int          accept_saved;
    bit          ready_random;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic model_err(input logic [31:0] a, input logic [1:0] sz);
        if (sz == 2'd3) return 1'b1;
        if (64'(a) >= 64'(4 * DEPTH)) return 1'b1;
        if (sz == 2'd1 && (a % 2) != 0) return 1'b1;
        if (sz == 2'd2 && (a % 4) != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz,
                                               input logic uns);
        logic [31:0] word;
        logic [31:0] v;
        int nb;
        int off;
        nb   = 1 << sz;
        off  = int'(a % 4);
        word = mmem[a / 4];
        v    = 32'd0;
        for (int k = 0; k < nb; k++) v[8*k +: 8] = word[8*(off+k) +: 8];
        if (nb < 4 && !uns && v[8*nb-1]) begin
            for (int k = 8 * nb; k < 32; k++) v[k] = 1'b1;
        end
        return v;
    endfunction

    task automatic model_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
        int nb;
        int off;
        nb  = 1 << sz;
        off = int'(a % 4);
        for (int k = 0; k < nb; k++) mmem[a / 4][8*(off+k) +: 8] = wd[8*k +: 8];
    endtask

    // ---------------- per-cycle compare process ----------------
    task automatic monitor();
        bit exp_ready;
        bit e;
        forever begin
            @(negedge clk);
            if (rst) begin
                check1("req_ready_in_reset", req_ready, 1'b0);
                exp_q.delete();
                pc_q.delete();
                err_q.delete();
                pend_valid = 0;
                post_reset = 1;
            end else begin
                if (post_reset) begin
                    check1("rst_resp_valid", resp_valid, 1'b0);
                    check32("rst_resp_pc", resp_pc, 32'd0);
                    check32("rst_resp_data", resp_data, 32'd0);
                    check1("rst_resp_err", resp_err, 1'b0);
                    post_reset = 0;
                end
                exp_ready = !pend_valid;
                check1("req_ready", req_ready, exp_ready);
                if (pend_valid) begin
                    if (cyc < pend_due) begin
                        check1("resp_valid_early", resp_valid, 1'b0);
                    end else begin
                        check1("resp_valid", resp_valid, 1'b1);
                        check32("resp_pc", resp_pc, pc_q[0]);
                        check32("resp_data", resp_data, exp_q[0]);
                        check1("resp_err", resp_err, err_q[0]);
                        if (cyc == pend_due && pend_store) model_store(pend_addr, pend_size, pend_wdata);
                        if (resp_ready) begin
                            void'(exp_q.pop_front());
                            void'(pc_q.pop_front());
                            void'(err_q.pop_front());
                            pend_valid   = 0;
                            last_hs_edge = cyc + 1;
                        end
                    end
                end else begin
                    check1("resp_valid_idle", resp_valid, 1'b0);
                end
                if (exp_ready && req_valid) begin
                    e = model_err(req_addr, req_size);
                    err_q.push_back(e);
                    pc_q.push_back(req_pc);
                    exp_q.push_back((e || req_we) ? 32'd0 : model_load(req_addr, req_size, req_unsigned));
                    pend_valid       = 1;
                    pend_store       = req_we && !e;
                    pend_addr        = req_addr;
                    pend_size        = req_size;
                    pend_wdata       = req_wdata;
                    pend_due         = cyc + 1 + (req_miss ? MISS : HIT);
                    last_accept_edge = cyc + 1;
                    accept_count++;
                end
            end
        end
    endtask

    task automatic ready_gen();
        forever begin
            @(posedge clk);
            #1;
            if (ready_random) resp_ready = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic watchdog();
        #2000000;
        n_cmp++;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    endtask

    // ---------------- driver tasks ----------------
    task automatic start_req(input logic we, input logic [1:0] sz, input logic uns, input logic miss,
                             input logic [31:0] a, input logic [31:0] wd, input logic [31:0] pc);
        accept_saved = accept_count;
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = sz;
        req_unsigned = uns;
        req_miss     = miss;
        req_addr     = a;
        req_wdata    = wd;
        req_pc       = pc;
    endtask

    task automatic wait_accept();
        bit done;
        done = 0;
        for (int i = 0; i < 80 && !done; i++) begin
            @(posedge clk);
            if (accept_count != accept_saved) done = 1;
        end
        #1;
        req_valid = 1'b0;
        check1("accept_in_time", done, 1'b1);
    endtask

    task automatic issue(input logic we, input logic [1:0] sz, input logic uns, input logic miss,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] pc);
        @(posedge clk);
        #1;
        start_req(we, sz, uns, miss, a, wd, pc);
        wait_accept();
    endtask

    task automatic wait_resp(input string name, input logic [31:0] pc, input logic [31:0] data,
                             input logic err, input int lat);
        bit seen;
        seen = 0;
        for (int i = 0; i < 80 && !seen; i++) begin
            @(negedge clk);
            if (resp_valid === 1'b1) seen = 1;
        end
        check1({name, "_seen"}, seen, 1'b1);
        if (seen) begin
            check32({name, "_pc"}, resp_pc, pc);
            check32({name, "_data"}, resp_data, data);
            check1({name, "_err"}, resp_err, err);
            check32({name, "_lat"}, 32'(cyc - last_accept_edge), 32'(lat));
        end
    endtask

    task automatic rand_txn();
        logic [31:0] a;
        logic [1:0]  sz;
        int r;
        r = $urandom_range(0, 19);
        if (r == 0) a = 32'h100 + $urandom_range(0, 255);
        else if (r == 1) a = $urandom;
        else a = $urandom_range(0, 63);
        sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
        issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              a, $urandom, $urandom);
        repeat ($urandom_range(0, 2)) @(posedge clk);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        for (int i = 0; i < DEPTH; i++) mmem[i] = 32'd0;
        rst          = 1'b1;
        req_valid    = 1'b0;
        req_pc       = 32'd0;
        req_addr     = 32'd0;
        req_wdata    = 32'd0;
        req_we       = 1'b0;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        req_miss     = 1'b0;
        resp_ready   = 1'b1;
        ready_random = 0;
        pend_valid   = 0;
        post_reset   = 0;
        accept_count = 0;
        fork
            monitor();
            ready_gen();
            watchdog();
        join_none

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Give every word the bench will read a known value.
        for (int w = 0; w < 16; w++) issue(1'b1, 2'd2, 1'b0, 1'b0, 32'(4 * w), $urandom, 32'(w));

        // Word store / load, hit latency.
        issue(1'b1, 2'd2, 1'b0, 1'b0, 32'h4, 32'h23, 32'h100);
        wait_resp("sw4", 32'h100, 32'h0, 1'b0, 1);
        issue(1'b0, 2'd2, 1'b0, 1'b0, 32'h4, 32'h0, 32'h104);
        wait_resp("lw4", 32'h104, 32'h23, 1'b0, 1);

        // Miss latency.
        issue(1'b1, 2'd2, 1'b0, 1'b1, 32'h8, 32'h46, 32'h108);
        wait_resp("sw8_miss", 32'h108, 32'h0, 1'b0, 4);
        issue(1'b0, 2'd2, 1'b0, 1'b1, 32'h8, 32'h0, 32'h10C);
        wait_resp("lw8_miss", 32'h10C, 32'h46, 1'b0, 4);

        // Byte lanes and extension.
        issue(1'b1, 2'd0, 1'b0, 1'b0, 32'h5, 32'h80, 32'h110);
        wait_resp("sb5", 32'h110, 32'h0, 1'b0, 1);
        issue(1'b0, 2'd0, 1'b0, 1'b0, 32'h5, 32'h0, 32'h114);
        wait_resp("lb5", 32'h114, 32'hFFFFFF80, 1'b0, 1);
        issue(1'b0, 2'd0, 1'b1, 1'b0, 32'h5, 32'h0, 32'h118);
        wait_resp("lbu5", 32'h118, 32'h00000080, 1'b0, 1);
        issue(1'b0, 2'd2, 1'b0, 1'b0, 32'h4, 32'h0, 32'h11C);
        wait_resp("lw4_merged", 32'h11C, 32'h00008023, 1'b0, 1);

        // Error cases: misaligned, out-of-range, illegal size.
        issue(1'b0, 2'd1, 1'b0, 1'b0, 32'h3, 32'h0, 32'h120);
        wait_resp("lh3_err", 32'h120, 32'h0, 1'b1, 1);
        issue(1'b1, 2'd2, 1'b0, 1'b0, 32'h6, 32'hFFFFFFFF, 32'h124);
        wait_resp("sw6_err", 32'h124, 32'h0, 1'b1, 1);
        issue(1'b0, 2'd2, 1'b0, 1'b0, 32'h4, 32'h0, 32'h128);
        wait_resp("lw4_after_err", 32'h128, 32'h00008023, 1'b0, 1);
        issue(1'b0, 2'd2, 1'b0, 1'b1, 32'h100, 32'h0, 32'h12C);
        wait_resp("lw_oor", 32'h12C, 32'h0, 1'b1, 4);
        issue(1'b0, 2'd3, 1'b0, 1'b0, 32'h4, 32'h0, 32'h130);
        wait_resp("size11", 32'h130, 32'h0, 1'b1, 1);
        issue(1'b0, 2'd1, 1'b1, 1'b0, 32'h4, 32'h0, 32'h134);
        wait_resp("lhu4", 32'h134, 32'h00008023, 1'b0, 1);

        // Response back-pressure for three cycles, next request waiting.
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        issue(1'b0, 2'd2, 1'b0, 1'b0, 32'h4, 32'h0, 32'h140);
        wait_resp("stall_lw4", 32'h140, 32'h00008023, 1'b0, 1);
        repeat (3) @(posedge clk);
        #1;
        resp_ready = 1'b1;
        start_req(1'b0, 2'd2, 1'b0, 1'b0, 32'h8, 32'h0, 32'h144);
        wait_accept();
        check32("accept_after_hs", 32'(last_accept_edge - last_hs_edge), 32'd1);
        wait_resp("after_stall_lw8", 32'h144, 32'h46, 1'b0, 1);

        // Reset in the middle of a miss store.
        issue(1'b1, 2'd2, 1'b0, 1'b0, 32'hC, 32'h0, 32'h150);
        wait_resp("swC_zero", 32'h150, 32'h0, 1'b0, 1);
        issue(1'b1, 2'd2, 1'b0, 1'b1, 32'hC, 32'hDEADBEEF, 32'h154);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check1("no_resp_after_rst", resp_valid, 1'b0);
        end
        issue(1'b0, 2'd2, 1'b0, 1'b0, 32'hC, 32'h0, 32'h158);
        wait_resp("lwC_after_rst", 32'h158, 32'h0, 1'b0, 1);

        // Randomized traffic with random response back-pressure.
        ready_random = 1;
        for (int t = 0; t < 300; t++) rand_txn();
        ready_random = 0;
        @(posedge clk);
        #1;
        resp_ready = 1'b1;
        repeat (10) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
